// File: rtl/mem_arbiter.sv
// Block-fill arbiter between I-cache and D-cache misses sharing one main-memory read port.
// Issues 8 pipelined word reads per fill and stalls the pipeline while any miss is pending.
module mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_miss,
    input  logic [15:0] i_miss_addr,
    input  logic        d_miss,
    input  logic [15:0] d_miss_addr,
    input  logic        mem_data_valid,
    output logic        mem_en,
    output logic [15:0] mem_addr,
    output logic        i_fill_we,
    output logic        d_fill_we,
    output logic [2:0]  fill_word,
    output logic        i_fill_done,
    output logic        d_fill_done,
    output logic        pipe_wen
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_FILL = 2'd1,
        D_FILL = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [15:0] BLOCK_MASK = 16'hFFF0;

    state_t      r_state;
    logic [3:0]  r_issue_cnt;
    logic [3:0]  r_recv_cnt;
    logic [15:0] r_base;
    logic        r_grant_d;

    logic        w_filling;
    logic        w_issuing;
    logic        w_recv;

    assign w_filling = (r_state == I_FILL) || (r_state == D_FILL);
    assign w_issuing = w_filling && !r_issue_cnt[3];
    assign w_recv    = w_filling && mem_data_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_issue_cnt <= 4'd0;
            r_recv_cnt  <= 4'd0;
            r_base      <= 16'h0000;
            r_grant_d   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    // D-side wins ties: a stalled load/store blocks retirement sooner.
                    if (d_miss) begin
                        r_state     <= D_FILL;
                        r_base      <= d_miss_addr & BLOCK_MASK;
                        r_grant_d   <= 1'b1;
                        r_issue_cnt <= 4'd0;
                        r_recv_cnt  <= 4'd0;
                    end else if (i_miss) begin
                        r_state     <= I_FILL;
                        r_base      <= i_miss_addr & BLOCK_MASK;
                        r_grant_d   <= 1'b0;
                        r_issue_cnt <= 4'd0;
                        r_recv_cnt  <= 4'd0;
                    end
                end
                I_FILL, D_FILL: begin
                    if (w_issuing) begin
                        r_issue_cnt <= r_issue_cnt + 4'd1;
                    end
                    if (mem_data_valid) begin
                        r_recv_cnt <= r_recv_cnt + 4'd1;
                        if (r_recv_cnt == 4'd7) begin
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Outputs are forced quiet while reset is asserted, even if state has not cleared yet.
    assign mem_en      = !rst && w_issuing;
    assign mem_addr    = mem_en ? (r_base + {12'h000, r_issue_cnt[2:0], 1'b0}) : 16'h0000;
    assign d_fill_we   = !rst && w_recv && (r_state == D_FILL);
    assign i_fill_we   = !rst && w_recv && (r_state == I_FILL);
    assign fill_word   = (!rst && w_recv) ? r_recv_cnt[2:0] : 3'd0;
    assign d_fill_done = !rst && (r_state == DONE) && r_grant_d;
    assign i_fill_done = !rst && (r_state == DONE) && !r_grant_d;
    assign pipe_wen    = (r_state == IDLE) && !i_miss && !d_miss;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: expected memory requests, fill writes and done pulses
// are queued when a miss is driven and consumed as the DUT produces them.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_miss, d_miss;
    logic [15:0] i_miss_addr, d_miss_addr;
    logic        mem_data_valid;
    logic        mem_en;
    logic [15:0] mem_addr;
    logic        i_fill_we, d_fill_we;
    logic [2:0]  fill_word;
    logic        i_fill_done, d_fill_done;
    logic        pipe_wen;

    mem_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .i_miss         (i_miss),
        .i_miss_addr    (i_miss_addr),
        .d_miss         (d_miss),
        .d_miss_addr    (d_miss_addr),
        .mem_data_valid (mem_data_valid),
        .mem_en         (mem_en),
        .mem_addr       (mem_addr),
        .i_fill_we      (i_fill_we),
        .d_fill_we      (d_fill_we),
        .fill_word      (fill_word),
        .i_fill_done    (i_fill_done),
        .d_fill_done    (d_fill_done),
        .pipe_wen       (pipe_wen)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; logic [15:0] addr; } mem_exp_t;
    typedef struct { int cyc; logic is_d; logic [2:0] word; } fill_exp_t;
    typedef struct { int cyc; logic is_d; } done_exp_t;

    mem_exp_t  mem_q[$];
    fill_exp_t fill_q[$];
    done_exp_t done_q[$];

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   busy_until = -1;
    logic [3:0] vpipe = 4'b0000;
    logic en_seen = 1'b0;
    logic drop_d = 1'b0;
    logic drop_i = 1'b0;
    int   c0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Queue a complete 8-word fill granted in cycle g.
    task automatic push_fill(input int g, input logic is_d, input logic [15:0] base);
        for (int k = 0; k < 8; k++) begin
            mem_q.push_back('{g + 1 + k, base + 16'(2 * k)});
            fill_q.push_back('{g + 5 + k, is_d, 3'(k)});
        end
        done_q.push_back('{g + 13, is_d});
    endtask

    task automatic monitor();
        mem_exp_t  me;
        fill_exp_t fe;
        done_exp_t de;
        en_seen = mem_en;
        if (mem_en) begin
            if (mem_q.size() == 0) chk("mem_unexpected", mem_en, 0);
            else begin
                me = mem_q.pop_front();
                chk("mem_cycle", cyc, me.cyc);
                chk("mem_addr", mem_addr, me.addr);
            end
        end else begin
            chk("mem_addr_idle", mem_addr, 16'h0000);
        end
        if (i_fill_we || d_fill_we) begin
            if (fill_q.size() == 0) chk("fill_unexpected", {i_fill_we, d_fill_we}, 0);
            else begin
                fe = fill_q.pop_front();
                chk("fill_cycle", cyc, fe.cyc);
                chk("fill_sel", {i_fill_we, d_fill_we}, fe.is_d ? 2'b01 : 2'b10);
                chk("fill_word", fill_word, fe.word);
            end
        end
        if (i_fill_done || d_fill_done) begin
            if (done_q.size() == 0) chk("done_unexpected", {i_fill_done, d_fill_done}, 0);
            else begin
                de = done_q.pop_front();
                chk("done_cycle", cyc, de.cyc);
                chk("done_sel", {i_fill_done, d_fill_done}, de.is_d ? 2'b01 : 2'b10);
            end
            if (d_fill_done) drop_d = 1'b1;
            if (i_fill_done) drop_i = 1'b1;
        end
        chk("pipe_wen", pipe_wen, (cyc > busy_until) && !i_miss && !d_miss);
    endtask

    // One clock cycle: observe at negedge, then drive the next cycle's inputs.
    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
        if (drop_d) begin d_miss = 1'b0; drop_d = 1'b0; end
        if (drop_i) begin i_miss = 1'b0; drop_i = 1'b0; end
        vpipe = {vpipe[2:0], en_seen};
        mem_data_valid = vpipe[3];
    endtask

    task automatic check_drained(input string tag);
        $display("check %s: queues mem=%0d fill=%0d done=%0d", tag, mem_q.size(), fill_q.size(), done_q.size());
        chk({tag, "_mem_left"}, mem_q.size(), 0);
        chk({tag, "_fill_left"}, fill_q.size(), 0);
        chk({tag, "_done_left"}, done_q.size(), 0);
        mem_q.delete();
        fill_q.delete();
        done_q.delete();
    endtask

    initial begin
        rst = 1'b1;
        i_miss = 1'b0;
        d_miss = 1'b0;
        i_miss_addr = 16'h0000;
        d_miss_addr = 16'h0000;
        mem_data_valid = 1'b0;

        // Reset: all outputs quiet, pipe_wen high with no misses.
        repeat (3) step();
        rst = 1'b0;
        repeat (2) step();
        check_drained("reset");

        // Single D fill, address change mid-fill ignored.
        c0 = cyc;
        d_miss = 1'b1;
        d_miss_addr = 16'h1236;
        push_fill(c0, 1'b1, 16'h1230);
        busy_until = c0 + 13;
        repeat (3) step();
        d_miss_addr = 16'h5555;
        repeat (15) step();
        check_drained("d_fill");

        // Simultaneous misses: D first, then I granted in cycle 14.
        c0 = cyc;
        d_miss = 1'b1;
        d_miss_addr = 16'h2000;
        i_miss = 1'b1;
        i_miss_addr = 16'h3458;
        push_fill(c0, 1'b1, 16'h2000);
        push_fill(c0 + 14, 1'b0, 16'h3450);
        busy_until = c0 + 27;
        repeat (31) step();
        check_drained("both");

        // I miss arrives mid D fill; its base is taken at its own grant.
        c0 = cyc;
        d_miss = 1'b1;
        d_miss_addr = 16'h4000;
        push_fill(c0, 1'b1, 16'h4000);
        push_fill(c0 + 14, 1'b0, 16'h6000);
        busy_until = c0 + 27;
        repeat (5) step();
        i_miss = 1'b1;
        i_miss_addr = 16'h5000;
        repeat (5) step();
        i_miss_addr = 16'h600C;
        repeat (6) step();
        i_miss_addr = 16'h7000;
        repeat (15) step();
        check_drained("i_during_d");

        // Reset in cycle 6 of a fill: fill abandoned, late data ignored.
        c0 = cyc;
        d_miss = 1'b1;
        d_miss_addr = 16'h8004;
        for (int k = 0; k < 5; k++) mem_q.push_back('{c0 + 1 + k, 16'h8000 + 16'(2 * k)});
        fill_q.push_back('{c0 + 5, 1'b1, 3'd0});
        busy_until = c0 + 6;
        repeat (6) step();
        rst = 1'b1;
        d_miss = 1'b0;
        step();
        rst = 1'b0;
        repeat (8) step();
        check_drained("mid_reset");

        // Stray data-valid pulses while idle.
        for (int k = 0; k < 4; k++) begin
            mem_data_valid = 1'b1;
            step();
        end
        step();
        check_drained("stray");

        // Top-of-memory block: no wrap past FFFE.
        c0 = cyc;
        i_miss = 1'b1;
        i_miss_addr = 16'hFFFE;
        push_fill(c0, 1'b0, 16'hFFF0);
        busy_until = c0 + 13;
        repeat (17) step();
        check_drained("top_block");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
